// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for a shared MESI snooping bus.
// Grants one cache at a time, broadcasts its request, gathers snoop acks and answers the requester.
module snoop_bus_arbiter #(
  parameter int NUM_CACHES    = 4,
  parameter int ADDR_W        = 32,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CACHES-1:0]          req,
  input  logic [2*NUM_CACHES-1:0]        req_op,
  input  logic [ADDR_W*NUM_CACHES-1:0]   req_addr,
  output logic [NUM_CACHES-1:0]          grant,
  output logic                           bus_valid,
  output logic [1:0]                     bus_op,
  output logic [ADDR_W-1:0]              bus_addr,
  output logic [$clog2(NUM_CACHES)-1:0]  bus_src,
  input  logic [NUM_CACHES-1:0]          snoop_ack,
  input  logic [NUM_CACHES-1:0]          snoop_share,
  input  logic [NUM_CACHES-1:0]          snoop_flush,
  output logic                           resp_valid,
  output logic                           resp_share,
  output logic                           resp_flush,
  output logic                           resp_err
);

  localparam int SRC_W = $clog2(NUM_CACHES);
  localparam int CNT_W = $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [1:0] OP_PUTX = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_BCAST, S_SNOOP, S_RESP} state_t;

  state_t                 state;
  logic [SRC_W-1:0]       rr_ptr;
  logic [NUM_CACHES-1:0]  ack_seen;
  logic [NUM_CACHES-1:0]  share_acc;
  logic [NUM_CACHES-1:0]  flush_acc;
  logic [CNT_W-1:0]       snoop_cnt;

  logic                   pick_found;
  logic [SRC_W-1:0]       pick_idx;
  logic [NUM_CACHES-1:0]  src_mask;
  logic [NUM_CACHES-1:0]  acks_now;
  logic [NUM_CACHES-1:0]  share_now;
  logic [NUM_CACHES-1:0]  flush_now;
  logic                   ack_all;
  logic                   timed_out;
  logic [SRC_W-1:0]       rr_next;

  // First requester at or after rr_ptr, wrapping; works for non power-of-two cache counts.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (!pick_found && req[(int'(rr_ptr) + i) % NUM_CACHES]) begin
        pick_found = 1'b1;
        pick_idx   = SRC_W'((int'(rr_ptr) + i) % NUM_CACHES);
      end
    end
  end

  // The requester never snoops itself, so its ack/share/flush lines are masked off.
  assign src_mask  = NUM_CACHES'(1) << bus_src;
  assign acks_now  = snoop_ack & ~src_mask;
  assign share_now = share_acc | (snoop_share & acks_now);
  assign flush_now = flush_acc | (snoop_flush & acks_now);
  assign ack_all   = &(ack_seen | acks_now | src_mask);
  assign timed_out = (snoop_cnt == CNT_W'(SNOOP_TIMEOUT - 1));
  assign rr_next   = (bus_src == SRC_W'(NUM_CACHES - 1)) ? '0 : bus_src + SRC_W'(1);

  // NOTE: state and outputs are flops, so only non-blocking assignments appear here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      bus_valid  <= 1'b0;
      bus_op     <= '0;
      bus_addr   <= '0;
      bus_src    <= '0;
      resp_valid <= 1'b0;
      resp_share <= 1'b0;
      resp_flush <= 1'b0;
      resp_err   <= 1'b0;
      ack_seen   <= '0;
      share_acc  <= '0;
      flush_acc  <= '0;
      snoop_cnt  <= '0;
    end else begin
      // Strobes are single-cycle: cleared here, re-armed only on entry to their own state.
      grant      <= '0;
      bus_valid  <= 1'b0;
      resp_valid <= 1'b0;
      resp_share <= 1'b0;
      resp_flush <= 1'b0;
      resp_err   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (pick_found) begin
            bus_op    <= req_op[2*pick_idx +: 2];
            bus_addr  <= req_addr[ADDR_W*pick_idx +: ADDR_W];
            bus_src   <= pick_idx;
            grant     <= NUM_CACHES'(1) << pick_idx;
            bus_valid <= 1'b1;
            state     <= S_BCAST;
          end
        end

        S_BCAST: begin
          ack_seen  <= '0;
          share_acc <= '0;
          flush_acc <= '0;
          snoop_cnt <= '0;
          state     <= S_SNOOP;
        end

        S_SNOOP: begin
          if (bus_op == OP_PUTX) begin
            // A writeback is not snooped; it only occupies the minimum one-cycle slot.
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (ack_all) begin
            resp_valid <= 1'b1;
            resp_share <= |share_now;
            resp_flush <= |flush_now;
            state      <= S_RESP;
          end else if (timed_out) begin
            resp_valid <= 1'b1;
            resp_share <= |share_now;
            resp_flush <= |flush_now;
            resp_err   <= 1'b1;
            state      <= S_RESP;
          end else begin
            ack_seen  <= ack_seen | acks_now;
            share_acc <= share_now;
            flush_acc <= flush_now;
            snoop_cnt <= snoop_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          rr_ptr <= rr_next;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: reset, basic GETS, round-robin, late acks,
// snoop timeout, PUTX bypass and reset during a snoop.
module tb_snoop_bus_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int TMO = 15;
  localparam int SW  = $clog2(N);

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [2*N-1:0]    req_op;
  logic [AW*N-1:0]   req_addr;
  logic [N-1:0]      grant;
  logic              bus_valid;
  logic [1:0]        bus_op;
  logic [AW-1:0]     bus_addr;
  logic [SW-1:0]     bus_src;
  logic [N-1:0]      snoop_ack;
  logic [N-1:0]      snoop_share;
  logic [N-1:0]      snoop_flush;
  logic              resp_valid;
  logic              resp_share;
  logic              resp_flush;
  logic              resp_err;

  int checks   = 0;
  int failures = 0;
  int bv_count = 0;
  int bv_start;

  snoop_bus_arbiter #(.NUM_CACHES(N), .ADDR_W(AW), .SNOOP_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_op(req_op), .req_addr(req_addr),
    .grant(grant), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src),
    .snoop_ack(snoop_ack), .snoop_share(snoop_share), .snoop_flush(snoop_flush),
    .resp_valid(resp_valid), .resp_share(resp_share), .resp_flush(resp_flush), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_valid === 1'b1) bv_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [AW-1:0] addr);
    req[idx]              = 1'b1;
    req_op[2*idx +: 2]    = op;
    req_addr[AW*idx +: AW] = addr;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 64'(grant), 64'h0);
    check({tag, "_bus_valid"}, 64'(bus_valid), 64'h0);
    check({tag, "_bus_op"}, 64'(bus_op), 64'h0);
    check({tag, "_bus_addr"}, 64'(bus_addr), 64'h0);
    check({tag, "_bus_src"}, 64'(bus_src), 64'h0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
    check({tag, "_resp_sfe"}, 64'({resp_share, resp_flush, resp_err}), 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    req = '0; req_op = '0; req_addr = '0;
    snoop_ack = '0; snoop_share = '0; snoop_flush = '0;
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b0;

    // 1: cache 0 GETS 0x40, caches 1..3 ack without sharing
    set_req(0, 2'd0, 32'h40);
    step();
    check("t1_bus_valid", 64'(bus_valid), 64'h1);
    check("t1_grant", 64'(grant), 64'h1);
    check("t1_bus_op", 64'(bus_op), 64'h0);
    check("t1_bus_addr", 64'(bus_addr), 64'h40);
    check("t1_bus_src", 64'(bus_src), 64'h0);
    snoop_ack = 4'b1110;
    step();
    check("t1_bcast_over", 64'({grant, bus_valid, resp_valid}), 64'h0);
    step();
    check("t1_resp_valid", 64'(resp_valid), 64'h1);
    check("t1_resp_sfe", 64'({resp_share, resp_flush, resp_err}), 64'h0);
    req = '0;
    snoop_ack = '0;
    step();
    check("t1_resp_gone", 64'(resp_valid), 64'h0);

    // 2: all four request continuously; rr_ptr restarts at 0 after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 2'd0, AW'(32'h100 * (i + 1)));
    snoop_ack = 4'b1111;
    bv_start = bv_count;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t2_grant_%0d", k), 64'(grant), 64'(4'b0001 << (k % N)));
      check($sformatf("t2_onehot_%0d", k), 64'($onehot(grant)), 64'h1);
      check($sformatf("t2_src_%0d", k), 64'(bus_src), 64'(k % N));
      check($sformatf("t2_addr_%0d", k), 64'(bus_addr), 64'(32'h100 * ((k % N) + 1)));
      step();
      check($sformatf("t2_bv_low_%0d", k), 64'(bus_valid), 64'h0);
      step();
      check($sformatf("t2_resp_%0d", k), 64'(resp_valid), 64'h1);
      if (k == 4) begin
        req = '0;
        snoop_ack = '0;
      end
      step();
    end
    check("t2_bus_valid_count", 64'(bv_count - bv_start), 64'd5);

    // 3: cache 2 GETS; cache 0 acks with share+flush in SNOOP cycle 1, caches 1,3 in cycle 3
    set_req(2, 2'd0, 32'h80);
    step();
    check("t3_grant", 64'(grant), 64'b0100);
    check("t3_src", 64'(bus_src), 64'h2);
    step();
    snoop_ack = 4'b0001; snoop_share = 4'b0001; snoop_flush = 4'b0001;
    step();
    check("t3_wait_c1", 64'(resp_valid), 64'h0);
    snoop_ack = '0; snoop_share = '0; snoop_flush = '0;
    step();
    check("t3_wait_c2", 64'(resp_valid), 64'h0);
    snoop_ack = 4'b1010;
    step();
    check("t3_resp_valid", 64'(resp_valid), 64'h1);
    check("t3_resp_share", 64'(resp_share), 64'h1);
    check("t3_resp_flush", 64'(resp_flush), 64'h1);
    check("t3_resp_err", 64'(resp_err), 64'h0);
    req = '0;
    snoop_ack = '0;
    step();

    // 4: cache 1 GETX; cache 3 never acks -> timeout after TMO SNOOP cycles
    set_req(1, 2'd1, 32'h1234_5680);
    step();
    check("t4_grant", 64'(grant), 64'b0010);
    check("t4_bus_op", 64'(bus_op), 64'h1);
    check("t4_bus_addr", 64'(bus_addr), 64'h1234_5680);
    snoop_ack = 4'b0101;
    step();
    for (int c = 1; c < TMO; c++) begin
      step();
      check($sformatf("t4_wait_%0d", c), 64'(resp_valid), 64'h0);
    end
    step();
    check("t4_resp_valid", 64'(resp_valid), 64'h1);
    check("t4_resp_err", 64'(resp_err), 64'h1);
    check("t4_resp_share", 64'(resp_share), 64'h0);
    req = '0;
    snoop_ack = '0;
    step();

    // 5: cache 3 PUTX; snoop lines active but ignored
    set_req(3, 2'd3, 32'hC0);
    snoop_ack = 4'b0111; snoop_share = 4'b0111; snoop_flush = 4'b0111;
    step();
    check("t5_grant", 64'(grant), 64'b1000);
    check("t5_bus_op", 64'(bus_op), 64'h3);
    check("t5_src", 64'(bus_src), 64'h3);
    step();
    check("t5_no_early_resp", 64'(resp_valid), 64'h0);
    step();
    check("t5_resp_valid", 64'(resp_valid), 64'h1);
    check("t5_resp_sfe", 64'({resp_share, resp_flush, resp_err}), 64'h0);
    req = '0;
    snoop_ack = '0; snoop_share = '0; snoop_flush = '0;
    step();

    // 6: reset in the middle of a cache 1 snoop; transaction is dropped
    set_req(1, 2'd0, 32'h200);
    step();
    check("t6_grant", 64'(grant), 64'b0010);
    step();
    step();
    reset = 1'b1;
    step();
    check_idle_outputs("t6_after_reset");
    reset = 1'b0;
    req = '0;
    step();
    check("t6_no_resp", 64'({resp_valid, bus_valid}), 64'h0);
    set_req(2, 2'd0, 32'h300);
    step();
    check("t6_grant_c2", 64'(grant), 64'b0100);
    check("t6_src_c2", 64'(bus_src), 64'h2);
    check("t6_addr_c2", 64'(bus_addr), 64'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
